framebuf_arbiter: RTL and testbench

Arbitrates the single-port frame-buffer SRAM (640x480 pixels, one word per pixel, addresses 0x00000-0x4AFFF) between two requesters. The display fetch path reads pixels. The host/loader path writes pixels. Display reads have priority; a starvation limiter guarantees the writer progress. Sits between the pixel address generation / loader logic and the SRAM pins.

---
 rtl/framebuf_arbiter.sv | 165 ++++++++++++++++
 tb/tb_framebuf_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuf_arbiter.sv
// framebuf_arbiter
//   Shares the single-port frame-buffer SRAM (640x480 words, 0x00000-0x4AFFF)
//   between the display fetch path (reads) and the host/loader path (writes).
//   Reads win arbitration by default. A starvation counter hands the memory
//   to a pending write after STARVE_MAX consecutive read grants.
//
//   Access sequence: IDLE (grant) -> ACCESS (MEM_WAIT+1 cycles, mem_ce=1)
//   -> DONE (ack pulse) -> IDLE. This gives MEM_WAIT+3 cycles per access.
//
//   Optional build macro FB_ADDR_CHECK_EN: addresses above MAX_ADDR are
//   rejected at grant time. The FSM skips ACCESS and acks with rd_err/wr_err
//   set. Without the macro there is no range check, and rd_err/wr_err are
//   always 0.
//
// Ports
//   clk, n_rst                     clock, synchronous active-low reset
//   rd_req/rd_addr                 display read request (held until rd_ack)
//   rd_ack/rd_data/rd_err          read completion pulse, registered data, reject flag
//   wr_req/wr_addr/wr_data         loader write request (held until wr_ack)
//   wr_ack/wr_err                  write completion pulse, reject flag
//   mem_ce/mem_we/mem_addr/
//   mem_wdata/mem_rdata            SRAM pins
//   busy                           high whenever the FSM is not in IDLE
module framebuf_arbiter #(
  parameter int                ADDR_W     = 20,
  parameter int                DATA_W     = 16,
  parameter int                MEM_WAIT   = 1,
  parameter int                STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = 20'h4AFFF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              rd_err,
  output logic              wr_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [2:0] WAIT_LAST  = 3'(MEM_WAIT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic [3:0]        starve_cnt;
  logic              gnt_wr;
  logic              grant_rd;
  logic              grant_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic              reject;

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
  endfunction

  // Arbitration only happens in IDLE; DONE never grants, so a request that
  // is still high during its own ack cycle cannot be granted twice.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE) begin
      if (wr_req && (!rd_req || starve_cnt == STARVE_LIM)) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end
    end
  end

  assign gnt_addr = grant_wr ? wr_addr : rd_addr;

`ifdef FB_ADDR_CHECK_EN
  assign reject = (gnt_addr > MAX_ADDR);
`else
  assign reject = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      starve_cnt <= 4'd0;
      gnt_wr     <= 1'b0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_data    <= '0;
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_err     <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          // The counter only tracks reads that overtook a waiting write.
          if (!wr_req || grant_wr) begin
            starve_cnt <= 4'd0;
          end else if (grant_rd) begin
            starve_cnt <= starve_inc(starve_cnt);
          end
          if (grant_rd || grant_wr) begin
            gnt_wr   <= grant_wr;
            wait_cnt <= 3'd0;
            if (reject) begin
              // An out-of-range address goes straight to DONE; the SRAM is never touched.
              state  <= DONE;
              rd_ack <= grant_rd;
              wr_ack <= grant_wr;
              rd_err <= grant_rd;
              wr_err <= grant_wr;
            end else begin
              state    <= ACCESS;
              mem_ce   <= 1'b1;
              mem_we   <= grant_wr;
              mem_addr <= gnt_addr;
              if (grant_wr) begin
                mem_wdata <= wr_data;
              end
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            state  <= DONE;
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
            rd_ack <= ~gnt_wr;
            wr_ack <= gnt_wr;
            if (!gnt_wr) begin
              rd_data <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuf_arbiter.sv
module tb_framebuf_arbiter;

  localparam int          MW   = 1;
  localparam int          SMAX = 4;
  localparam logic [19:0] MAXA = 20'h4AFFF;
`ifdef FB_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        rd_req = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        wr_req = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_err;
  logic        wr_err;
  logic        mem_ce;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  framebuf_arbiter #(
    .ADDR_W(20), .DATA_W(16), .MEM_WAIT(MW), .STARVE_MAX(SMAX), .MAX_ADDR(MAXA)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_err(rd_err), .wr_err(wr_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // SRAM model and the reference memory image
  logic [15:0] sram    [0:20'h4AFFF];
  logic [15:0] ref_mem [0:20'h4AFFF];
  assign mem_rdata = (mem_addr <= MAXA) ? sram[mem_addr[18:0]] : 16'hDEAD;

  int n_vec = 0;
  int n_miss = 0;
  int n_edge = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  // Reference model: transaction timing from grant edge arithmetic
  int          next_free = 0;
  int          g_edge = 0;
  int          ack_edge = -1;
  int          starve = 0;
  bit          g_valid = 1'b0;
  bit          g_wr = 1'b0;
  bit          g_rej = 1'b0;
  logic [15:0] g_rdval = '0;
  logic        e_rd_ack, e_wr_ack, e_rd_err, e_wr_err, e_ce, e_we, e_busy;
  logic [19:0] e_mem_addr = '0;
  logic [15:0] e_mem_wdata = '0;
  logic [15:0] e_rd_data = '0;

  task automatic model_edge();
    bit          gr;
    bit          gw;
    logic [19:0] a;
    n_edge++;
    e_rd_ack = 1'b0; e_wr_ack = 1'b0; e_rd_err = 1'b0; e_wr_err = 1'b0;
    if (!n_rst) begin
      g_valid = 1'b0; next_free = n_edge + 1; starve = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_rd_data = '0;
      e_ce = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      return;
    end
    if (n_edge >= next_free) begin
      gr = rd_req && !(wr_req && starve == SMAX);
      gw = wr_req && !gr;
      if (gw || !wr_req) starve = 0;
      else if (gr) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
      if (gr || gw) begin
        a = gw ? wr_addr : rd_addr;
        g_valid = 1'b1; g_wr = gw; g_edge = n_edge;
        g_rej = CHK_EN && (a > MAXA);
        if (g_rej) begin
          ack_edge = n_edge; next_free = n_edge + 2;
        end else begin
          ack_edge = n_edge + MW + 1; next_free = n_edge + MW + 3;
          e_mem_addr = a;
          if (gw) begin
            e_mem_wdata = wr_data;
            if (a <= MAXA) ref_mem[a[18:0]] = wr_data;
          end else begin
            g_rdval = (a <= MAXA) ? ref_mem[a[18:0]] : 16'hDEAD;
          end
        end
      end
    end
    e_ce   = g_valid && !g_rej && (n_edge <= g_edge + MW);
    e_we   = e_ce && g_wr;
    e_busy = g_valid && (n_edge < next_free - 1);
    if (g_valid && n_edge == ack_edge) begin
      e_rd_ack = !g_wr; e_wr_ack = g_wr;
      e_rd_err = g_rej && !g_wr; e_wr_err = g_rej && g_wr;
      if (!g_wr && !g_rej) e_rd_data = g_rdval;
    end
  endtask

  // Requester behaviour and per-phase bookkeeping
  bit   rd_en = 1'b0, wr_en = 1'b0;
  int   rd_gmax = 0, wr_gmax = 0, rd_gap = 0, wr_gap = 0;
  int   step_k = 0, n_acks = 0, cnt_rd = 0, cnt_wr = 0, cnt_err = 0;
  logic [31:0] ack_log = '0;
  int   ack_cyc [0:63];

  function automatic logic [19:0] pick_addr();
    int r;
    int sel;
    r   = $urandom_range(0, 15);
    sel = $urandom_range(0, 9);
    if (sel < 7) return 20'(r);
    else if (sel < 9) return 20'h4AFF0 + 20'(r);
    else return 20'h4B000 + 20'(r % 4);
  endfunction

  task automatic new_phase();
    step_k = 0; n_acks = 0; cnt_rd = 0; cnt_wr = 0; cnt_err = 0; ack_log = '0;
    for (int i = 0; i < 64; i++) ack_cyc[i] = 0;
  endtask

  task automatic drive_reqs();
    if (rd_req && rd_ack) begin
      if (rd_en && rd_gmax == 0) rd_addr = pick_addr();
      else begin rd_req = 1'b0; rd_gap = (rd_gmax == 0) ? 0 : $urandom_range(0, rd_gmax); end
    end else if (!rd_req && rd_en) begin
      if (rd_gap > 0) rd_gap--;
      else begin rd_req = 1'b1; rd_addr = pick_addr(); end
    end
    if (wr_req && wr_ack) begin
      if (wr_en && wr_gmax == 0) begin wr_addr = pick_addr(); wr_data = 16'($urandom); end
      else begin wr_req = 1'b0; wr_gap = (wr_gmax == 0) ? 0 : $urandom_range(0, wr_gmax); end
    end else if (!wr_req && wr_en) begin
      if (wr_gap > 0) wr_gap--;
      else begin wr_req = 1'b1; wr_addr = pick_addr(); wr_data = 16'($urandom); end
    end
  endtask

  task automatic step();
    bit          do_wr;
    logic [19:0] wa;
    logic [15:0] wd;
    model_edge();
    do_wr = mem_ce && mem_we;
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clk);
    if (do_wr === 1'b1 && wa <= MAXA) sram[wa[18:0]] = wd;
    #1;
    step_k++;
    check_val("rd_ack",    32'(rd_ack),    32'(e_rd_ack));
    check_val("wr_ack",    32'(wr_ack),    32'(e_wr_ack));
    check_val("rd_err",    32'(rd_err),    32'(e_rd_err));
    check_val("wr_err",    32'(wr_err),    32'(e_wr_err));
    check_val("mem_ce",    32'(mem_ce),    32'(e_ce));
    check_val("mem_we",    32'(mem_we),    32'(e_we));
    check_val("busy",      32'(busy),      32'(e_busy));
    check_val("mem_addr",  32'(mem_addr),  32'(e_mem_addr));
    check_val("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
    check_val("rd_data",   32'(rd_data),   32'(e_rd_data));
    if (rd_ack === 1'b1 || wr_ack === 1'b1) begin
      ack_log = {ack_log[30:0], wr_ack};
      if (n_acks < 64) ack_cyc[n_acks] = step_k + 1;
      n_acks++;
    end
    if (rd_ack === 1'b1) cnt_rd++;
    if (wr_ack === 1'b1) cnt_wr++;
    if (rd_err === 1'b1 || wr_err === 1'b1) cnt_err++;
    drive_reqs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i <= 32'h4AFFF; i++) begin
      sram[i]    = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end

    // Reset values
    n_rst = 1'b0;
    run(3);
    n_rst = 1'b1;

    // Single read returning 0xBEEF
    sram[20'h00123] = 16'hBEEF; ref_mem[20'h00123] = 16'hBEEF;
    new_phase();
    rd_req = 1'b1; rd_addr = 20'h00123;
    run(6);
    check_val("p1_rd_acks", 32'(cnt_rd), 32'd1);
    check_val("p1_ack_cycle", 32'(ack_cyc[0]), 32'(MW + 3));
    check_val("p1_rd_data", 32'(rd_data), 32'h0000BEEF);

    // Write to the top address, then read it back
    new_phase();
    wr_req = 1'b1; wr_addr = 20'h4AFFF; wr_data = 16'h1234;
    run(5);
    check_val("p2_wr_acks", 32'(cnt_wr), 32'd1);
    check_val("p2_ack_cycle", 32'(ack_cyc[0]), 32'(MW + 3));
    new_phase();
    rd_req = 1'b1; rd_addr = 20'h4AFFF;
    run(5);
    check_val("p2_readback", 32'(rd_data), 32'h00001234);

    // Both held continuously: starvation limiter ordering
    new_phase();
    rd_en = 1'b1; wr_en = 1'b1; rd_gmax = 0; wr_gmax = 0;
    rd_req = 1'b1; rd_addr = pick_addr();
    wr_req = 1'b1; wr_addr = pick_addr(); wr_data = 16'($urandom);
    run(10 * (MW + 3));
    check_val("p3_ack_count", 32'(n_acks), 32'd10);
    check_val("p3_order", 32'(ack_log[9:0]), 32'b0000100001);
    check_val("p3_first_ack", 32'(ack_cyc[0]), 32'(MW + 3));
    for (int i = 1; i < 10; i++) check_val("p3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(MW + 3));
    rd_en = 1'b0; wr_en = 1'b0;
    run(12);

    // Reset during the second ACCESS cycle of a read
    new_phase();
    rd_req = 1'b1; rd_addr = 20'h00200;
    run(2);
    n_rst = 1'b0;
    run(1);
    check_val("p4_ce_after_rst", 32'(mem_ce), 32'd0);
    check_val("p4_busy_after_rst", 32'(busy), 32'd0);
    check_val("p4_rd_data_rst", 32'(rd_data), 32'd0);
    n_rst = 1'b1;
    run(6);
    check_val("p4_rd_acks", 32'(cnt_rd), 32'd1);
    check_val("p4_rd_data", 32'(rd_data), 32'h00000E03);

    // Out-of-range read address
    new_phase();
    rd_req = 1'b1; rd_addr = 20'h4B000;
    run(6);
    check_val("p5_rd_acks", 32'(cnt_rd), 32'd1);
    check_val("p5_err_count", 32'(cnt_err), CHK_EN ? 32'd1 : 32'd0);
    check_val("p5_ack_cycle", 32'(ack_cyc[0]), CHK_EN ? 32'd2 : 32'(MW + 3));
    check_val("p5_rd_data", 32'(rd_data), CHK_EN ? 32'h00000E03 : 32'h0000DEAD);

    // Writer alone, re-requesting immediately after each ack
    new_phase();
    wr_en = 1'b1; wr_gmax = 0;
    wr_req = 1'b1; wr_addr = pick_addr(); wr_data = 16'($urandom);
    run(3 * (MW + 3));
    check_val("p6_wr_acks", 32'(cnt_wr), 32'd3);
    check_val("p6_rd_acks", 32'(cnt_rd), 32'd0);
    wr_en = 1'b0;
    run(8);

    // Randomised traffic with occasional resets
    for (int blk = 0; blk < 4; blk++) begin
      rd_en = 1'b1; wr_en = 1'b1;
      rd_gmax = $urandom_range(0, 3); wr_gmax = $urandom_range(0, 3);
      for (int i = 0; i < 500; i++) begin
        n_rst = ($urandom_range(0, 249) != 0);
        step();
      end
    end
    n_rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0;
    run(12);
    check_val("end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
